// File: rtl/sram_controller_if.sv
// CPU-side load/store request channel for sram_controller.
// The master issues requests; the slave (controller) answers with ready/done/err/rdata.
interface sram_controller_if;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;

    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wdata,
        input  o_ready, o_done, o_err, o_rdata
    );

    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wdata,
        output o_ready, o_done, o_err, o_rdata
    );
endinterface

// File: rtl/sram_controller.sv
// Byte/halfword/word load-store responder driving a 16-bit asynchronous SRAM.
// Big-endian lane mapping; words take two SRAM cycles; every access ends with an idle DONE cycle.
module sram_controller #(
    parameter int SRAM_AW = 20
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] o_sram_addr,
    inout  wire  [15:0]        io_sram_dq,
    output logic               o_sram_ce_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_we_n,
    output logic               o_sram_ub_n,
    output logic               o_sram_lb_n
);

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        DONE
    } state_t;

    state_t       state;

    logic         r_we;
    logic [2:0]   r_f3;
    logic         r_a0;
    logic [15:0]  r_wlo;
    logic [15:0]  r_hi;
    logic         dq_oe;
    logic [15:0]  dq_out;
    logic         done_q;
    logic         err_q;
    logic [31:0]  rdata_q;
    logic         ready;

    logic         illegal;
    logic         req_byte;
    logic [SRAM_AW-1:0] req_idx;
    logic [15:0]  req_wd;
    logic [7:0]   ld_byte;
    logic [31:0]  ld_data;
    logic         unused_addr_hi;

    assign io_sram_dq   = dq_oe ? dq_out : 16'hzzzz;
    assign ready        = (state == IDLE) & ~i_rst;
    assign bus.o_ready  = ready;
    assign bus.o_done   = done_q;
    assign bus.o_err    = err_q;
    assign bus.o_rdata  = rdata_q;

    assign req_idx        = bus.i_addr[SRAM_AW:1];
    assign req_byte       = (bus.i_funct3[1:0] == 2'b00);
    assign unused_addr_hi = ^bus.i_addr[31:SRAM_AW+1];

    always_comb begin
        illegal = 1'b0;
        case (bus.i_funct3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = bus.i_addr[0];
            3'b010:  illegal = |bus.i_addr[1:0];
            3'b100:  illegal = bus.i_we;
            3'b101:  illegal = bus.i_we | bus.i_addr[0];
            default: illegal = 1'b1;
        endcase
    end

    // First SRAM cycle's write data: SB replicates the byte, SW sends the upper half first.
    always_comb begin
        req_wd = bus.i_wdata[31:16];
        case (bus.i_funct3[1:0])
            2'b00:   req_wd = {2{bus.i_wdata[7:0]}};
            2'b01:   req_wd = bus.i_wdata[15:0];
            default: req_wd = bus.i_wdata[31:16];
        endcase
    end

    always_comb begin
        ld_byte = r_a0 ? io_sram_dq[7:0] : io_sram_dq[15:8];
        ld_data = {r_hi, io_sram_dq};
        case (r_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b001:  ld_data = {{16{io_sram_dq[15]}}, io_sram_dq};
            3'b101:  ld_data = {16'h0000, io_sram_dq};
            default: ld_data = {r_hi, io_sram_dq};
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            r_we        <= 1'b0;
            r_f3        <= '0;
            r_a0        <= 1'b0;
            r_wlo       <= '0;
            r_hi        <= '0;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            o_sram_addr <= '0;
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            o_sram_ub_n <= 1'b1;
            o_sram_lb_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (bus.i_req) begin
                        r_we  <= bus.i_we;
                        r_f3  <= bus.i_funct3;
                        r_a0  <= bus.i_addr[0];
                        r_wlo <= bus.i_wdata[15:0];
                        if (illegal) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state       <= ACC0;
                            o_sram_addr <= req_idx;
                            o_sram_ce_n <= 1'b0;
                            o_sram_oe_n <= bus.i_we;
                            o_sram_we_n <= ~bus.i_we;
                            o_sram_ub_n <= req_byte & bus.i_addr[0];
                            o_sram_lb_n <= req_byte & ~bus.i_addr[0];
                            dq_oe       <= bus.i_we;
                            dq_out      <= req_wd;
                        end
                    end
                end
                ACC0, ACC1: begin
                    if (state == ACC0 && r_f3[1:0] == 2'b10) begin
                        state       <= ACC1;
                        o_sram_addr <= o_sram_addr + SRAM_AW'(1);
                        dq_out      <= r_wlo;
                        r_hi        <= io_sram_dq;
                    end else begin
                        state       <= DONE;
                        done_q      <= 1'b1;
                        o_sram_ce_n <= 1'b1;
                        o_sram_oe_n <= 1'b1;
                        o_sram_we_n <= 1'b1;
                        o_sram_ub_n <= 1'b1;
                        o_sram_lb_n <= 1'b1;
                        dq_oe       <= 1'b0;
                        if (!r_we) begin
                            rdata_q <= ld_data;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM on the bus.
// A bench-side probe driver shows whether the controller has released DQ.
module tb_sram_controller;
    localparam int AW = 20;

    logic CLOCK_50 = 1'b0;
    logic rst;
    always #5 CLOCK_50 = ~CLOCK_50;

    sram_controller_if bus ();

    logic [AW-1:0] sram_addr;
    wire  [15:0]   sram_dq;
    logic          ce_n, oe_n, we_n, ub_n, lb_n;

    sram_controller #(.SRAM_AW(AW)) dut (
        .i_clk       (CLOCK_50),
        .i_rst       (rst),
        .bus         (bus),
        .o_sram_addr (sram_addr),
        .io_sram_dq  (sram_dq),
        .o_sram_ce_n (ce_n),
        .o_sram_oe_n (oe_n),
        .o_sram_we_n (we_n),
        .o_sram_ub_n (ub_n),
        .o_sram_lb_n (lb_n)
    );

    logic [15:0] mem [0:1023];
    logic        probe_en = 1'b0;
    logic [15:0] probe_val = 16'h5A5A;

    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr[9:0]] : 16'hzzzz;
    assign sram_dq = probe_en ? probe_val : 16'hzzzz;

    always @(posedge CLOCK_50) begin
        if (!ce_n && !we_n) begin
            if (!ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
            if (!lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [15:0]   r_dq   [1:8];
    logic [AW-1:0] r_addr [1:8];
    logic          r_we_n [1:8];
    logic          r_oe_n [1:8];
    logic          r_ce_n [1:8];
    logic          r_ub_n [1:8];
    logic          r_lb_n [1:8];
    logic          r_rdy  [1:8];
    int            done_cyc;
    int            oe_low;
    logic          got_err;
    logic [31:0]   got_rdata;

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge CLOCK_50);
        check("ready_before_req", {31'b0, bus.o_ready}, 32'd1);
        bus.i_req    = 1'b1;
        bus.i_we     = we;
        bus.i_funct3 = f3;
        bus.i_addr   = addr;
        bus.i_wdata  = wdata;
        @(posedge CLOCK_50);
        #1;
        bus.i_req    = 1'b0;
        bus.i_we     = ~we;
        bus.i_funct3 = 3'b111;
        bus.i_addr   = 32'hFFFF_FFFF;
        bus.i_wdata  = 32'h0F0F_0F0F;
        done_cyc = 0;
        oe_low   = 0;
        got_err  = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLOCK_50);
            r_dq[c]   = sram_dq;
            r_addr[c] = sram_addr;
            r_we_n[c] = we_n;
            r_oe_n[c] = oe_n;
            r_ce_n[c] = ce_n;
            r_ub_n[c] = ub_n;
            r_lb_n[c] = lb_n;
            r_rdy[c]  = bus.o_ready;
            if (!oe_n) oe_low++;
            if (bus.o_done) begin
                done_cyc  = c;
                got_err   = bus.o_err;
                got_rdata = bus.o_rdata;
                break;
            end
        end
        if (done_cyc == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    logic done_seen;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        rst          = 1'b1;
        bus.i_req    = 1'b0;
        bus.i_we     = 1'b0;
        bus.i_funct3 = 3'b000;
        bus.i_addr   = '0;
        bus.i_wdata  = '0;

        // reset state, DQ released (probe value visible unaltered)
        repeat (3) @(negedge CLOCK_50);
        probe_en = 1'b1;
        #1;
        check("rst_ready", {31'b0, bus.o_ready}, 32'd0);
        check("rst_done",  {31'b0, bus.o_done}, 32'd0);
        check("rst_err",   {31'b0, bus.o_err}, 32'd0);
        check("rst_rdata", bus.o_rdata, 32'h0);
        check("rst_addr",  32'(sram_addr), 32'h0);
        check("rst_ctrl",  {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        check("rst_dq_z",  {16'b0, sram_dq}, 32'h5A5A);
        probe_en = 1'b0;
        @(negedge CLOCK_50);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, bus.o_ready}, 32'd1);

        // SW 0x100 <- DEADBEEF
        run_req(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        check("sw_done_cyc", done_cyc, 32'd3);
        check("sw_err",   {31'b0, got_err}, 32'd0);
        check("sw_c1_addr", 32'(r_addr[1]), 32'h80);
        check("sw_c1_dq",   {16'b0, r_dq[1]}, 32'hDEAD);
        check("sw_c1_ctrl", {27'b0, r_ce_n[1], r_oe_n[1], r_we_n[1], r_ub_n[1], r_lb_n[1]}, 32'b01000);
        check("sw_c2_addr", 32'(r_addr[2]), 32'h81);
        check("sw_c2_dq",   {16'b0, r_dq[2]}, 32'hBEEF);
        check("sw_c2_ctrl", {27'b0, r_ce_n[2], r_oe_n[2], r_we_n[2], r_ub_n[2], r_lb_n[2]}, 32'b01000);
        check("sw_c3_ctrl", {27'b0, r_ce_n[3], r_oe_n[3], r_we_n[3], r_ub_n[3], r_lb_n[3]}, 32'h1F);
        check("sw_busy",    {29'b0, r_rdy[1], r_rdy[2], r_rdy[3]}, 32'd0);
        check("sw_addr_hold", 32'(r_addr[3]), 32'h81);
        check("sw_mem80", {16'b0, mem[10'h80]}, 32'hDEAD);
        check("sw_mem81", {16'b0, mem[10'h81]}, 32'hBEEF);
        check("sw_rdata_hold", got_rdata, 32'h0);

        // LW 0x100
        run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        check("lw_done_cyc", done_cyc, 32'd3);
        check("lw_rdata",    got_rdata, 32'hDEAD_BEEF);
        check("lw_oe_low",   oe_low, 32'd2);
        check("lw_we_n",     {30'b0, r_we_n[1], r_we_n[2]}, 32'b11);
        check("lw_lanes",    {30'b0, r_ub_n[1], r_lb_n[1]}, 32'b00);
        check("lw_c2_addr",  32'(r_addr[2]), 32'h81);

        // SB 0x101 <- A5
        run_req(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5);
        check("sb_done_cyc", done_cyc, 32'd2);
        check("sb_lanes",    {30'b0, r_ub_n[1], r_lb_n[1]}, 32'b10);
        check("sb_dq",       {16'b0, r_dq[1]}, 32'hA5A5);
        check("sb_mem80",    {16'b0, mem[10'h80]}, 32'hDEA5);

        run_req(1'b0, 3'b000, 32'h0000_0101, 32'h0);
        check("lb_odd",       got_rdata, 32'hFFFF_FFA5);
        check("lb_odd_lanes", {30'b0, r_ub_n[1], r_lb_n[1]}, 32'b10);
        run_req(1'b0, 3'b100, 32'h0000_0101, 32'h0);
        check("lbu_odd",      got_rdata, 32'h0000_00A5);
        run_req(1'b0, 3'b000, 32'h0000_0100, 32'h0);
        check("lb_even",       got_rdata, 32'hFFFF_FFDE);
        check("lb_even_lanes", {30'b0, r_ub_n[1], r_lb_n[1]}, 32'b01);
        run_req(1'b0, 3'b100, 32'h0000_0100, 32'h0);
        check("lbu_even",     got_rdata, 32'h0000_00DE);

        // SH 0x102 <- 8001, then LH / LHU
        run_req(1'b1, 3'b001, 32'h0000_0102, 32'h1234_8001);
        check("sh_done_cyc", done_cyc, 32'd2);
        check("sh_mem81",    {16'b0, mem[10'h81]}, 32'h8001);
        run_req(1'b0, 3'b001, 32'h0000_0102, 32'h0);
        check("lh_done_cyc", done_cyc, 32'd2);
        check("lh_rdata",    got_rdata, 32'hFFFF_8001);
        run_req(1'b0, 3'b101, 32'h0000_0102, 32'h0);
        check("lhu_done_cyc", done_cyc, 32'd2);
        check("lhu_rdata",    got_rdata, 32'h0000_8001);

        // illegal requests: misaligned LW, misaligned SH, reserved funct3, SBU store
        run_req(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        check("ill_lw_cyc",   done_cyc, 32'd1);
        check("ill_lw_err",   {31'b0, got_err}, 32'd1);
        check("ill_lw_ce",    {31'b0, r_ce_n[1]}, 32'd1);
        check("ill_lw_rdata", got_rdata, 32'h0000_8001);
        run_req(1'b1, 3'b001, 32'h0000_0103, 32'h0000_7777);
        check("ill_sh_cyc",   done_cyc, 32'd1);
        check("ill_sh_err",   {31'b0, got_err}, 32'd1);
        check("ill_sh_ce",    {31'b0, r_ce_n[1]}, 32'd1);
        check("ill_sh_mem81", {16'b0, mem[10'h81]}, 32'h8001);
        run_req(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        check("ill_f3_cyc",   done_cyc, 32'd1);
        check("ill_f3_err",   {31'b0, got_err}, 32'd1);
        check("ill_f3_ce",    {31'b0, r_ce_n[1]}, 32'd1);
        check("ill_f3_rdata", got_rdata, 32'h0000_8001);
        check("ill_addr_hold", 32'(r_addr[1]), 32'h81);
        run_req(1'b1, 3'b100, 32'h0000_0100, 32'h0000_0011);
        check("ill_sbu_err",  {31'b0, got_err}, 32'd1);
        check("ill_sbu_mem",  {16'b0, mem[10'h80]}, 32'hDEA5);

        // reset in ACC0 of a word store: nothing written, no done
        @(negedge CLOCK_50);
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_funct3 = 3'b010;
        bus.i_addr = 32'h0000_0200; bus.i_wdata = 32'h1234_5678;
        @(posedge CLOCK_50);
        #1;
        bus.i_req = 1'b0;
        @(negedge CLOCK_50);
        check("r0_we_active", {31'b0, we_n}, 32'd0);
        check("r0_dq_drive",  {16'b0, sram_dq}, 32'h1234);
        #1;
        rst = 1'b1;
        probe_en = 1'b1;
        #1;
        check("r0_ctrl_high", {29'b0, ce_n, oe_n, we_n}, 32'b111);
        check("r0_dq_z",      {16'b0, sram_dq}, 32'h5A5A);
        done_seen = bus.o_done;
        repeat (2) begin
            @(posedge CLOCK_50);
            #1;
            done_seen = done_seen | bus.o_done;
        end
        probe_en = 1'b0;
        @(negedge CLOCK_50);
        rst = 1'b0;
        #1;
        check("r0_ready", {31'b0, bus.o_ready}, 32'd1);
        @(posedge CLOCK_50);
        #1;
        done_seen = done_seen | bus.o_done;
        check("r0_no_done", {31'b0, done_seen}, 32'd0);
        check("r0_mem100",  {16'b0, mem[10'h100]}, 32'h0);

        // reset in ACC1 of a word store: only the upper half lands
        run_req(1'b0, 3'b000, 32'h0000_0100, 32'h0);
        @(negedge CLOCK_50);
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_funct3 = 3'b010;
        bus.i_addr = 32'h0000_0204; bus.i_wdata = 32'hCAFE_F00D;
        @(posedge CLOCK_50);
        #1;
        bus.i_req = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("r1_acc1_addr", 32'(sram_addr), 32'h103);
        #1;
        rst = 1'b1;
        #1;
        check("r1_we_high", {31'b0, we_n}, 32'd1);
        @(negedge CLOCK_50);
        rst = 1'b0;
        check("r1_mem102", {16'b0, mem[10'h102]}, 32'hCAFE);
        check("r1_mem103", {16'b0, mem[10'h103]}, 32'h0000);
        check("r1_rdata_rst", bus.o_rdata, 32'h0);

        repeat (2) @(negedge CLOCK_50);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
